tt_puf_sampler: RTL and testbench

Challenge sequencer and response collector for the key-controlled multiplexer-chain race block. It drives the block's 4-bit key and its `pulse` input, then samples the racing output `multblockout` through a synchronizer. Each challenge is applied VOTES times and resolved by majority vote, and the resolved bits are assembled into a RESP_BITS-wide response word. The block sits directly around the race block: its `key_4`/`pulse` outputs feed that block, and it consumes that block's output.

---
 rtl/tt_puf_sampler_pkg.sv | 7 +
 rtl/tt_sync2.sv | 21 ++
 rtl/tt_puf_sampler.sv | 95 +++++++++
 tb/tb_tt_puf_sampler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tt_puf_sampler_pkg.sv
// tt_puf_pkg: shared state encoding and default parameters for the PUF challenge sampler.
package tt_puf_pkg;
  typedef enum logic [2:0] {IDLE, ARM, FIRE, SAMPLE, DECIDE, DONE} puf_state_t;
  localparam int RESP_BITS_DEF = 16;
  localparam int VOTES_DEF = 7;
  localparam int SETTLE_DEF = 8;
endpackage

// File: rtl/tt_sync2.sv
// tt_sync2: generic two-flop synchronizer with asynchronous active-low reset.
module tt_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end
  assign q_o = sync_q;
endmodule

// File: rtl/tt_puf_sampler.sv
// tt_puf_sampler: sequences challenges into the race block, majority-votes each
// challenge's synchronized response and shifts the resolved bits into a word.
module tt_puf_sampler
  import tt_puf_pkg::*;
#(
  parameter int RESP_BITS = RESP_BITS_DEF,
  parameter int VOTES     = VOTES_DEF,
  parameter int SETTLE    = SETTLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [3:0]           chal_base,
  input  logic                 multblockout,
  output logic [3:0]           key_4,
  output logic                 pulse,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response
);
  localparam int IW = $clog2(RESP_BITS + 1);
  localparam int TW = $clog2(VOTES + 1);
  localparam int SW = $clog2(SETTLE + 1);

  puf_state_t state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] trial_q, trial_d, ones_q, ones_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0] chal_q, chal_d, key_q, key_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
  logic race_sync, accept, vote_bit;

  tt_sync2 #(.W(1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (multblockout),
    .q_o  (race_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
      trial_q  <= '0;
      ones_q   <= '0;
      idx_q    <= '0;
      chal_q   <= '0;
      key_q    <= '0;
      resp_q   <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      trial_q  <= trial_d;
      ones_q   <= ones_d;
      idx_q    <= idx_d;
      chal_q   <= chal_d;
      key_q    <= key_d;
      resp_q   <= resp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? ARM : IDLE;
      ARM:     state_d = (settle_q == SW'(SETTLE - 1)) ? FIRE : ARM;
      FIRE:    state_d = (settle_q == SW'(SETTLE - 1)) ? SAMPLE : FIRE;
      SAMPLE:  state_d = (trial_q == TW'(VOTES - 1)) ? DECIDE : ARM;
      DECIDE:  state_d = (idx_q == IW'(RESP_BITS - 1)) ? DONE : ARM;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The key is only recomputed on entry to ARM so it never moves under a live pulse.
  always_comb begin
    accept   = (state_q == IDLE) && start;
    vote_bit = ones_q > TW'(VOTES / 2);
    settle_d = ((state_q == ARM || state_q == FIRE) && state_d == state_q) ? settle_q + 1'b1 : '0;
    chal_d   = accept ? chal_base : chal_q;
    trial_d  = (accept || state_q == DECIDE) ? '0 : (state_q == SAMPLE) ? trial_q + 1'b1 : trial_q;
    ones_d   = (accept || state_q == DECIDE) ? '0 : (state_q == SAMPLE) ? ones_q + TW'(race_sync) : ones_q;
    idx_d    = accept ? '0 : (state_q == DECIDE) ? idx_q + 1'b1 : idx_q;
    resp_d   = accept ? '0 : (state_q == DECIDE) ? ((resp_q << 1) | RESP_BITS'(vote_bit)) : resp_q;
    key_d    = (state_d == ARM && state_q != ARM) ? chal_d + 4'(idx_d) : key_q;
  end

  always_comb begin
    pulse    = (state_q == FIRE) || (state_q == SAMPLE);
    busy     = state_q != IDLE;
    done     = state_q == DONE;
    key_4    = key_q;
    response = resp_q;
  end
endmodule

// File: tb/tb_tt_puf_sampler.sv
// tb_tt_puf_sampler: vector table plus scoreboard of expected runs, checked cycle by cycle.
module tb_tt_puf_sampler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] chal_base = '0;
  logic mb = 1'b0;
  logic [3:0] key_4;
  logic pulse, busy, done;
  logic [15:0] response;

  logic start2 = 1'b0;
  logic [3:0] chal2 = '0;
  logic [3:0] key2;
  logic pulse2, busy2, done2;
  logic [3:0] resp2;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  tt_puf_sampler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .chal_base(chal_base), .multblockout(mb),
    .key_4(key_4), .pulse(pulse), .busy(busy), .done(done), .response(response)
  );

  tt_puf_sampler #(.RESP_BITS(4), .VOTES(1), .SETTLE(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .chal_base(chal2), .multblockout(key2[1]),
    .key_4(key2), .pulse(pulse2), .busy(busy2), .done(done2), .response(resp2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Race-block model: constant, key-dependent, or a per-trial mask chosen by key_4[0].
  int mode = 0;
  logic cval = 1'b0;
  logic [6:0] mhi = '0, mlo = '0, msk;
  int cur_t0 = 0;
  int kk, tr;
  always @(negedge clk) begin
    kk = cyc - cur_t0 - 1;
    tr = (kk < 0) ? 0 : ((kk % 120) / 17 > 6 ? 6 : (kk % 120) / 17);
    msk = key_4[0] ? mhi : mlo;
    mb <= (mode == 0) ? cval : (mode == 1) ? key_4[0] : msk[tr];
  end

  typedef struct {
    int t0;
    logic [3:0] base;
    logic [15:0] resp;
  } exp_t;
  exp_t sb[$];

  int mk, mc, key_err = 0, pulse_err = 0, ctl_err = 0;
  logic [3:0] exp_key;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mk = cyc - sb[0].t0 - 1;
      if (mk >= 0 && mk <= 1920) begin
        mc = mk % 120;
        exp_key = sb[0].base + 4'((mk < 1920) ? mk / 120 : 15);
        if (key_4 !== exp_key) key_err++;
        if (pulse !== (mk < 1920 && mc != 119 && (mc % 17) >= 8)) pulse_err++;
        if (busy !== 1'b1 || done !== (mk == 1920)) ctl_err++;
      end
      if (done === 1'b1) begin
        chk("done_time", 32'(mk), 32'd1920);
        chk("response", 32'(response), 32'(sb[0].resp));
        chk("key_seq_errs", 32'(key_err), 0);
        chk("pulse_seq_errs", 32'(pulse_err), 0);
        chk("busy_done_errs", 32'(ctl_err), 0);
        key_err = 0;
        pulse_err = 0;
        ctl_err = 0;
        void'(sb.pop_front());
      end
    end
  end

  task automatic run_start(input logic [3:0] base, input logic [15:0] resp);
    @(negedge clk);
    chal_base = base;
    start = 1'b1;
    cur_t0 = cyc;
    sb.push_back('{cyc, base, resp});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2200 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      chk("done_timeout", 32'(sb.size()), 0);
      sb.delete();
    end
  endtask

  typedef struct {
    int mode;
    logic cval;
    logic [3:0] base;
    logic [6:0] mhi, mlo;
    logic [15:0] resp;
  } vec_t;
  vec_t tv[8];

  int t2;
  logic seen;

  initial begin
    tv[0] = '{0, 1'b1, 4'd0,  7'h00, 7'h00, 16'hFFFF};
    tv[1] = '{0, 1'b0, 4'd0,  7'h00, 7'h00, 16'h0000};
    tv[2] = '{1, 1'b0, 4'd0,  7'h00, 7'h00, 16'h5555};
    tv[3] = '{1, 1'b0, 4'd1,  7'h00, 7'h00, 16'hAAAA};
    tv[4] = '{1, 1'b0, 4'd15, 7'h00, 7'h00, 16'hAAAA};
    tv[5] = '{2, 1'b0, 4'd0,  7'b0101101, 7'b0010101, 16'h5555};
    tv[6] = '{2, 1'b0, 4'd0,  7'b1110000, 7'b0001111, 16'hAAAA};
    tv[7] = '{0, 1'b1, 4'd7,  7'h00, 7'h00, 16'hFFFF};

    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_key", 32'(key_4), 0);
    chk("rst_pulse", 32'(pulse), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_response", 32'(response), 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      mode = tv[v].mode;
      cval = tv[v].cval;
      mhi = tv[v].mhi;
      mlo = tv[v].mlo;
      run_start(tv[v].base, tv[v].resp);
      wait_done();
    end

    // Stray start mid-run with a different base must be ignored entirely.
    mode = 1;
    run_start(4'd0, 16'h5555);
    repeat (300) @(negedge clk);
    chal_base = 4'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // start raised in the DONE cycle is not accepted there.
    mode = 0;
    cval = 1'b1;
    run_start(4'd3, 16'hFFFF);
    seen = 1'b0;
    for (int i = 0; i < 2200 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk("done_seen", 32'(seen), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_busy", 32'(busy), 0);
    wait_done();
    repeat (2) @(negedge clk);
    chk("idle_after_done", 32'(busy), 0);

    // Asynchronous reset mid-run aborts while the pulse is high.
    run_start(4'd0, 16'hFFFF);
    repeat (400) @(negedge clk);
    for (int i = 0; i < 40 && !pulse; i++) @(negedge clk);
    chk("pulse_before_reset", 32'(pulse), 1);
    sb.delete();
    rst_n = 1'b0;
    #1;
    chk("abort_pulse", 32'(pulse), 0);
    chk("abort_response", 32'(response), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_key", 32'(key_4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_start(4'd0, 16'hFFFF);
    wait_done();

    // Single-vote instance: each trial's value is the bit; done at t+33.
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      chal2 = (j == 0) ? 4'd0 : 4'd2;
      start2 = 1'b1;
      t2 = cyc;
      @(negedge clk);
      start2 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        seen = done2;
        if (!seen) @(negedge clk);
      end
      chk("v1_done_time", 32'(cyc - t2), 33);
      chk("v1_response", 32'(resp2), (j == 0) ? 32'h3 : 32'hC);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
